// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: control/strobe bundle between the phase sequencer and the
// rest of the 8-bit CPU (IR, ALU, PC, memory, accumulator, program loader).
interface cpu_seq_ctrl_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 3;

    logic          Load;
    logic [DW-1:0] data_in;
    logic [OW-1:0] opcode;
    logic          zero;

    logic [2:0]    phase;
    logic          sel;
    logic          rd;
    logic          wr;
    logic          ld_ir;
    logic          ld_ac;
    logic          inc_pc;
    logic          ld_pc;
    logic          clr_pc;
    logic          data_e;
    logic          halt;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    // Sequencer side
    modport slave (
        input  Load, data_in, opcode, zero,
        output phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, clr_pc,
               data_e, halt, ld_we, ld_addr, ld_data
    );

    // CPU / environment side
    modport master (
        output Load, data_in, opcode, zero,
        input  phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, clr_pc,
               data_e, halt, ld_we, ld_addr, ld_data
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: eight-phase fetch/execute sequencer for the 8-bit RISC CPU,
// with an optional program loader that writes data_in bytes into memory.
// Define CPU_LOADER_EN to build the loader (LOAD state, ld_* and clr_pc);
// without it Load is ignored and the loader outputs are tied to 0.
module cpu_seq_ctrl (
    input  logic          clock,
    input  logic          reset,
    cpu_seq_ctrl_if.slave bus
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned OW = 3;

    localparam logic [PW-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PW-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PW-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PW-1:0] PH_IDLE       = 3'd3;
    localparam logic [PW-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PW-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PW-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PW-1:0] PH_STORE      = 3'd7;

    localparam logic [OW-1:0] OP_HLT = 3'b000;
    localparam logic [OW-1:0] OP_SKZ = 3'b001;
    localparam logic [OW-1:0] OP_ADD = 3'b010;
    localparam logic [OW-1:0] OP_AND = 3'b011;
    localparam logic [OW-1:0] OP_XOR = 3'b100;
    localparam logic [OW-1:0] OP_LDA = 3'b101;
    localparam logic [OW-1:0] OP_STO = 3'b110;
    localparam logic [OW-1:0] OP_JMP = 3'b111;

    // S_CLR is the single clr_pc cycle between leaving LOAD and phase 0
    typedef enum logic [1:0] {
        S_EXEC = 2'd0,
        S_LOAD = 2'd1,
        S_CLR  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          load_req_c;
    logic          alu_op_c;
    logic          sel_c, rd_c, wr_c, ld_ir_c, ld_ac_c, inc_pc_c, ld_pc_c, data_e_c;

`ifdef CPU_LOADER_EN
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          ld_we_q, ld_we_d;
    logic          ld_take_c;

    assign load_req_c = bus.Load;
`else
    logic unused_load;

    assign unused_load = ^{bus.Load, bus.data_in};
    assign load_req_c  = 1'b0;
`endif

    assign alu_op_c = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                      (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

    // State and phase register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_EXEC;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state: phase walk, HLT capture, load entry/exit
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_EXEC: begin
                phase_d = phase_q + PW'(1);
                if ((phase_q == PH_OP_ADDR) && (bus.opcode == OP_HLT)) begin
                    state_d = S_HALT;
                    phase_d = phase_q;
                end else if ((phase_q == PH_STORE) && load_req_c) begin
                    state_d = S_LOAD;
                end
            end
            S_HALT: begin
                if (load_req_c) begin
                    state_d = S_LOAD;
                    phase_d = '0;
                end
            end
            S_LOAD: begin
                phase_d = '0;
                if (!load_req_c) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                phase_d = '0;
                state_d = S_EXEC;
            end
            default: begin
                state_d = S_EXEC;
                phase_d = '0;
            end
        endcase
    end

    // Datapath strobe decode from registered phase, opcode and zero
    always_comb begin
        sel_c    = 1'b0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        ld_ir_c  = 1'b0;
        ld_ac_c  = 1'b0;
        inc_pc_c = 1'b0;
        ld_pc_c  = 1'b0;
        data_e_c = 1'b0;
        if (state_q == S_EXEC) begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel_c = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel_c = 1'b1;
                    rd_c  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel_c   = 1'b1;
                    rd_c    = 1'b1;
                    ld_ir_c = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc_c = 1'b1;
                end
                PH_OP_FETCH: begin
                    rd_c = alu_op_c;
                end
                PH_ALU_OP: begin
                    rd_c     = alu_op_c;
                    inc_pc_c = (bus.opcode == OP_SKZ) && bus.zero;
                    ld_pc_c  = (bus.opcode == OP_JMP);
                    data_e_c = (bus.opcode == OP_STO);
                end
                PH_STORE: begin
                    rd_c     = alu_op_c;
                    ld_ac_c  = alu_op_c;
                    ld_pc_c  = (bus.opcode == OP_JMP);
                    wr_c     = (bus.opcode == OP_STO);
                    data_e_c = (bus.opcode == OP_STO);
                end
                default: begin
                    sel_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.phase  = phase_q;
    assign bus.sel    = sel_c;
    assign bus.rd     = rd_c;
    assign bus.wr     = wr_c;
    assign bus.ld_ir  = ld_ir_c;
    assign bus.ld_ac  = ld_ac_c;
    assign bus.inc_pc = inc_pc_c;
    assign bus.ld_pc  = ld_pc_c;
    assign bus.data_e = data_e_c;
    assign bus.halt   = (state_q == S_HALT);

`ifdef CPU_LOADER_EN
    // A byte is taken in LOAD and also on the cycle that enters LOAD
    assign ld_take_c = load_req_c &&
                       ((state_q == S_LOAD) || (state_q == S_HALT) ||
                        ((state_q == S_EXEC) && (phase_q == PH_STORE)));

    // Loader register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_addr_q <= '0;
            ld_data_q <= '0;
            ld_we_q   <= 1'b0;
        end else begin
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
            ld_we_q   <= ld_we_d;
        end
    end

    // Loader next state: capture byte, advance address after each write, clear on exit
    always_comb begin
        ld_we_d   = 1'b0;
        ld_data_d = ld_data_q;
        ld_addr_d = ld_addr_q;
        if (ld_we_q) begin
            ld_addr_d = ld_addr_q + AW'(1);
        end
        if (ld_take_c) begin
            ld_we_d   = 1'b1;
            ld_data_d = bus.data_in;
        end
        if ((state_q == S_LOAD) && !load_req_c) begin
            ld_addr_d = '0;
        end
    end

    assign bus.clr_pc  = (state_q == S_CLR);
    assign bus.ld_we   = ld_we_q;
    assign bus.ld_addr = ld_addr_q;
    assign bus.ld_data = ld_data_q;
`else
    assign bus.clr_pc  = 1'b0;
    assign bus.ld_we   = 1'b0;
    assign bus.ld_addr = '0;
    assign bus.ld_data = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed scoreboard bench for the CPU phase sequencer.
// The driver pushes one expected output record per clock; the monitor pops
// and compares on each falling edge.
module tb_cpu_seq_ctrl;
    logic clock;
    logic reset;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] ph;
        logic [7:0] strb;   // {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e}
        logic       halt;
        logic       clr;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] cur_data = 8'h00;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Expected strobes per phase 0..7 (phase 0 in the top byte)
    localparam logic [63:0] T_LDA  = 64'h80C0D0D0_04404048;
    localparam logic [63:0] T_SKZ1 = 64'h80C0D0D0_04000400;
    localparam logic [63:0] T_SKZ0 = 64'h80C0D0D0_04000000;
    localparam logic [63:0] T_JMP  = 64'h80C0D0D0_04000202;
    localparam logic [63:0] T_STO  = 64'h80C0D0D0_04000121;
    localparam logic [63:0] T_HLT  = 64'h80C0D0D0_04000000;

    function automatic exp_t mk(input logic [2:0] ph, input logic [7:0] strb,
                                input logic halt, input logic clr, input logic we,
                                input logic [4:0] addr, input string tag);
        exp_t e;
        e.ph   = ph;
        e.strb = strb;
        e.halt = halt;
        e.clr  = clr;
        e.we   = we;
        e.addr = addr;
        e.data = cur_data;
        e.tag  = tag;
        return e;
    endfunction

    // Queue the expectation for the current cycle, then move to the next cycle
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input logic [63:0] tbl,
                             input int first, input int last, input string tag);
        bus.opcode = op;
        bus.zero   = z;
        for (int p = first; p <= last; p++) begin
            step(mk(3'(p), tbl[63-8*p -: 8], 1'b0, 1'b0, 1'b0, 5'd0, tag));
        end
    endtask

    // Async reset pulse in the middle of the current cycle
    task automatic reset_pulse(input string tag);
        #2;
        reset    = 1'b0;
        cur_data = 8'h00;
        exp_q.push_back(mk(3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 5'd0, tag));
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compare one expectation per falling edge
    initial begin
        exp_t       e;
        logic [7:0] a_strb;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a_strb = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
                          bus.inc_pc, bus.ld_pc, bus.data_e};
                n_chk++;
                if (bus.phase !== e.ph || a_strb !== e.strb || bus.halt !== e.halt ||
                    bus.clr_pc !== e.clr || bus.ld_we !== e.we ||
                    bus.ld_addr !== e.addr || bus.ld_data !== e.data) begin
                    n_err++;
                    $display("FAIL %s @%0t: got ph=%0d strb=%h halt=%b clr=%b we=%b addr=%0d data=%h, want ph=%0d strb=%h halt=%b clr=%b we=%b addr=%0d data=%h",
                             e.tag, $time, bus.phase, a_strb, bus.halt, bus.clr_pc,
                             bus.ld_we, bus.ld_addr, bus.ld_data, e.ph, e.strb,
                             e.halt, e.clr, e.we, e.addr, e.data);
                end
            end
        end
    end

    // Driver
    initial begin
        reset       = 1'b0;
        bus.Load    = 1'b0;
        bus.data_in = 8'h00;
        bus.opcode  = OP_LDA;
        bus.zero    = 1'b0;
        @(posedge clock);
        #1;
        step(mk(3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 5'd0, "reset_state"));
        reset = 1'b1;

        run_instr(OP_LDA, 1'b0, T_LDA,  0, 7, "lda");
        run_instr(OP_ADD, 1'b1, T_LDA,  0, 7, "add_z1");
        run_instr(OP_SKZ, 1'b1, T_SKZ1, 0, 7, "skz_z1");
        run_instr(OP_SKZ, 1'b0, T_SKZ0, 0, 7, "skz_z0");
        run_instr(OP_JMP, 1'b0, T_JMP,  0, 7, "jmp");
        run_instr(OP_STO, 1'b1, T_STO,  0, 7, "sto");

        run_instr(OP_LDA, 1'b0, T_LDA,  0, 4, "lda_pre_rst");
        reset_pulse("rst_mid_p5");
        run_instr(OP_LDA, 1'b0, T_LDA,  0, 7, "lda_post_rst");

        run_instr(OP_HLT, 1'b0, T_HLT,  0, 4, "hlt");
        for (int i = 0; i < 20; i++) begin
`ifndef CPU_LOADER_EN
            if (i == 10) bus.Load = 1'b1;
`endif
            step(mk(3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, "halt_hold"));
        end
        bus.Load = 1'b0;
        reset_pulse("rst_from_halt");

`ifdef CPU_LOADER_EN
        // Three bytes, entered at an instruction boundary
        run_instr(OP_JMP, 1'b0, T_JMP, 0, 6, "jmp_pre_load");
        bus.Load    = 1'b1;
        bus.data_in = 8'hE3;
        step(mk(3'd7, 8'h02, 1'b0, 1'b0, 1'b0, 5'd0, "ld3_entry"));
        bus.data_in = 8'h00;
        cur_data    = 8'hE3;
        step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, "ld3_b0"));
        bus.data_in = 8'hBB;
        cur_data    = 8'h00;
        step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, "ld3_b1"));
        bus.Load    = 1'b0;
        cur_data    = 8'hBB;
        step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, "ld3_b2"));
        step(mk(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, "ld3_clr_pc"));
        run_instr(OP_LDA, 1'b0, T_LDA, 0, 7, "lda_after_ld3");

        // Load raised with HLT in phase 4: HLT wins, then 33 bytes from HALT
        run_instr(OP_HLT, 1'b0, T_HLT, 0, 3, "hlt2");
        bus.Load    = 1'b1;
        bus.data_in = 8'h40;
        step(mk(3'd4, 8'h04, 1'b0, 1'b0, 1'b0, 5'd0, "hlt_vs_load"));
        step(mk(3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, "halt_then_load"));
        for (int k = 1; k <= 33; k++) begin
            cur_data = 8'h40 + 8'(k - 1);
            if (k == 33) bus.Load = 1'b0;
            else         bus.data_in = 8'h40 + 8'(k);
            step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b1,
                    (k == 33) ? 5'd0 : 5'(k - 1), "ld33"));
        end
        step(mk(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, "ld33_clr_pc"));
        run_instr(OP_STO, 1'b0, T_STO, 0, 7, "sto_after_ld33");
`else
        // Load is ignored without the loader
        run_instr(OP_JMP, 1'b0, T_JMP, 0, 6, "jmp_pre_load");
        bus.Load    = 1'b1;
        bus.data_in = 8'hE3;
        step(mk(3'd7, 8'h02, 1'b0, 1'b0, 1'b0, 5'd0, "ld_ign_p7"));
        step(mk(3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 5'd0, "ld_ign_p0"));
        bus.Load = 1'b0;
        run_instr(OP_JMP, 1'b0, T_JMP, 1, 7, "jmp_post_ign");
        run_instr(OP_LDA, 1'b0, T_LDA, 0, 7, "lda_post_ign");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clock);
        end
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Phase sequencer and program-loader controller for the 8-bit RISC CPU. It drives the eight-phase fetch/execute cycle that generates every datapath strobe (memory read/write, IR/ACC/PC loads, address-mux select, data bus enable) from the IR opcode and the ALU zero flag. It also owns the load mode that writes `data_in` bytes into the 32-word memory before execution. It sits between the instruction register / ALU and the PC, memory and accumulator inside `CPU`.

## Interface
- `AW`, 5, memory address width (32 words)
- `clock`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `Load`  in  1  active-high load-mode request
- `data_in`  in  8  byte to be written to memory in load mode
- `opcode`  in  3  IR[7:5]: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111
- `zero`  in  1  accumulator-zero flag from ALU
- `phase`  out  3  current execute phase 0–7 (debug)
- `sel`  out  1  1 = memory addressed by PC, 0 = by IR[4:0]
- `rd`  out  1  memory read enable
- `wr`  out  1  memory write enable (execute STO)
- `ld_ir`  out  1  load instruction register
- `ld_ac`  out  1  load accumulator
- `inc_pc`  out  1  PC increment
- `ld_pc`  out  1  PC load from IR[4:0]
- `clr_pc`  out  1  one-cycle PC clear on load-mode exit
- `data_e`  out  1  drive accumulator onto memory data bus
- `halt`  out  1  CPU halted
- `ld_we`  out  1  loader memory write strobe
- `ld_addr`  out  AW  loader write address
- `ld_data`  out  8  loader write data (registered `data_in`)

## Operation
- States: `EXEC` (phases 0–7), `LOAD`, `HALT`. Reset enters `EXEC`, phase 0, `ld_addr`=0.
- ALUOP = ADD | AND | XOR | LDA.
- Strobes in EXEC are combinational decodes of the registered phase, `opcode` and `zero`:
  - 0 INST_ADDR: `sel`
  - 1 INST_FETCH: `sel`, `rd`
  - 2 INST_LOAD: `sel`, `rd`, `ld_ir`
  - 3 IDLE: `sel`, `rd`, `ld_ir`
  - 4 OP_ADDR: `inc_pc`
  - 5 OP_FETCH: `rd` if ALUOP
  - 6 ALU_OP: `rd` if ALUOP; `inc_pc` if SKZ & `zero`; `ld_pc` if JMP; `data_e` if STO
  - 7 STORE: `rd` and `ld_ac` if ALUOP; `ld_pc` if JMP; `wr` and `data_e` if STO
- Phase advances by 1 each clock and wraps 7 → 0.
- HLT: in phase 4 with opcode HLT, the next state is `HALT`.
  - In `HALT`: `halt`=1, `phase` frozen at 4, all other strobes 0.
  - `HALT` is left only by reset, or by `Load` when the loader is compiled in.
- Load entry: `Load`=1 is sampled only at the phase 7 → 0 boundary, or in `HALT`. A running instruction always completes.
- LOAD state: all EXEC strobes 0 and `phase`=0.
  - Each cycle with `Load`=1: `ld_data` ← `data_in`, `ld_we`=1, `ld_addr` increments after each write, 31 wraps to 0.
- Load exit: `Load`=0 in `LOAD` gives one cycle of `clr_pc`=1 and `ld_addr` ← 0, then `EXEC` phase 0.
- Reset mid-operation: immediate return to reset values, regardless of state.

## Timing
- Reset values: `phase`=0, `sel`=1. All other outputs 0, including `ld_addr`=0 and `ld_data`=0.
- One instruction takes 8 clocks. A taken SKZ gives 2 PC increments, so the next instruction is skipped.
- `zero` is sampled combinationally only in phase 6.
- `opcode` must be stable from phase 4 through phase 7 (guaranteed by IR load in phases 2–3).
- Loader write for byte n occurs on the clock after `data_in` is presented. First write address is 0.
- `Load` and HLT in the same phase-4 cycle: HLT wins, and `Load` is honoured from `HALT` on the next clock.

## Configuration
- `CPU_LOADER_EN` defined: `LOAD` state, `ld_we`/`ld_addr`/`ld_data`/`clr_pc` active as above.
- `CPU_LOADER_EN` undefined:
  - `Load` is ignored.
  - `ld_we`, `ld_addr`, `ld_data` and `clr_pc` are tied to 0.
  - `HALT` is left only by reset.

## Test plan
- Reset pulse low mid-phase 5 → next sample `phase`=0, `sel`=1, all other outputs 0, `halt`=0.
- opcode=101 (LDA), zero=0 → `rd` in phases 1,2,3,5,6,7; `ld_ac` only in phase 7; `inc_pc` only in phase 4; `wr`=0 throughout.
- opcode=001 (SKZ):
  - zero=1 → `inc_pc` in phases 4 and 6.
  - zero=0 → `inc_pc` only in phase 4.
- opcode=111 (JMP) → `ld_pc` in phases 6,7. opcode=110 (STO) → `data_e` in phases 6,7, `wr` only in phase 7, no `rd` in phases 5–7.
- opcode=000 in phase 4 → `halt`=1 from the next clock, held for 20 clocks, `phase` stays 4.
- With `CPU_LOADER_EN`: `Load`=1 for 3 clocks with `data_in` 0xE3, 0x00, 0xBB → `ld_we` 3 cycles at `ld_addr` 0,1,2 with matching `ld_data`. Then `clr_pc`=1 for one cycle, then phase 0.
- With `CPU_LOADER_EN`: 33 consecutive load bytes → `ld_addr` wraps to 0 on byte 33.
